// File: rtl/wash_sequencer.sv
// wash_sequencer: coin-started fill/wash/rinse/spin cycle; WASH_DRAIN_EN adds a DRAIN phase
module wash_sequencer #(
  parameter int CNT_W = 29,
  parameter int REP_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             coin,
  input  logic             pause,
  input  logic [REP_W-1:0] repeat_cnt,
  input  logic [CNT_W-1:0] fill_time,
  input  logic [CNT_W-1:0] wash_time,
  input  logic [CNT_W-1:0] rinse_time,
  input  logic [CNT_W-1:0] spin_time,
`ifdef WASH_DRAIN_EN
  input  logic [CNT_W-1:0] drain_time,
`endif
  output logic [2:0]       phase,
  output logic             busy,
  output logic [CNT_W-1:0] elapsed,
  output logic             wash_done
);
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FILLING  = 3'd1,
    WASHING  = 3'd2,
    RINSING  = 3'd3,
    SPINNING = 3'd4,
    DRAIN    = 3'd5
  } state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] f_q, w_q, r_q, s_q, dur, lim;
  logic [REP_W-1:0] rep_q;
  logic fin;
  state_t after_rinse;
`ifdef WASH_DRAIN_EN
  logic [CNT_W-1:0] d_q;
  assign after_rinse = DRAIN;
`else
  assign after_rinse = SPINNING;
`endif
  assign phase = state;
  assign busy  = state != IDLE;
  // duration of the active phase; zero behaves like one cycle
  always_comb begin
    dur = state == FILLING  ? f_q :
          state == WASHING  ? w_q :
          state == RINSING  ? r_q :
`ifdef WASH_DRAIN_EN
          state == DRAIN    ? d_q :
`endif
          state == SPINNING ? s_q : '0;
    lim = dur == '0 ? '0 : dur - 1'b1;
    fin = !pause && elapsed == lim;
  end
  // next-state selection; unused codes fall back to IDLE
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = coin ? FILLING : IDLE;
      FILLING:  state_n = fin ? WASHING : FILLING;
      WASHING:  state_n = fin ? RINSING : WASHING;
      RINSING:  state_n = !fin ? RINSING : rep_q != '0 ? WASHING : after_rinse;
`ifdef WASH_DRAIN_EN
      DRAIN:    state_n = fin ? SPINNING : DRAIN;
`endif
      SPINNING: state_n = fin ? IDLE : SPINNING;
      default:  state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end
  // configuration latch, pass counter, phase timer and completion pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      f_q       <= '0;
      w_q       <= '0;
      r_q       <= '0;
      s_q       <= '0;
`ifdef WASH_DRAIN_EN
      d_q       <= '0;
`endif
      rep_q     <= '0;
      elapsed   <= '0;
      wash_done <= 1'b0;
    end else begin
      if (state == IDLE && coin) begin
        f_q   <= fill_time;
        w_q   <= wash_time;
        r_q   <= rinse_time;
        s_q   <= spin_time;
`ifdef WASH_DRAIN_EN
        d_q   <= drain_time;
`endif
        rep_q <= repeat_cnt;
      end
      if (state == RINSING && fin && rep_q != '0) rep_q <= rep_q - 1'b1;
      elapsed   <= state_n != state ? '0 : (state != IDLE && !pause) ? elapsed + 1'b1 : elapsed;
      wash_done <= state == SPINNING && fin;
    end
  end
endmodule

// File: tb/tb_wash_sequencer.sv
// tb_wash_sequencer: scoreboard of expected phase segments checked against observed phase runs
module tb_wash_sequencer;
  localparam int CNT_W = 8;
  localparam int REP_W = 2;
  localparam int DD    = 3;
  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             coin = 1'b0;
  logic             pause = 1'b0;
  logic [REP_W-1:0] repeat_cnt = '0;
  logic [CNT_W-1:0] fill_time = '0, wash_time = '0, rinse_time = '0, spin_time = '0;
`ifdef WASH_DRAIN_EN
  logic [CNT_W-1:0] drain_time = '0;
`endif
  logic [2:0]       phase;
  logic             busy;
  logic [CNT_W-1:0] elapsed;
  logic             wash_done;
  typedef struct {
    logic [2:0] ph;
    int         len;
    int         el;
  } seg_t;
  seg_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  logic seen5 = 1'b0;

  wash_sequencer #(.CNT_W(CNT_W), .REP_W(REP_W)) dut (
    .clk(clk), .reset(reset), .coin(coin), .pause(pause), .repeat_cnt(repeat_cnt),
    .fill_time(fill_time), .wash_time(wash_time), .rinse_time(rinse_time), .spin_time(spin_time),
`ifdef WASH_DRAIN_EN
    .drain_time(drain_time),
`endif
    .phase(phase), .busy(busy), .elapsed(elapsed), .wash_done(wash_done)
  );

  always #5 clk = ~clk;

  // remember whether the drain code ever appears
  always @(negedge clk) if (phase === 3'd5) seen5 = 1'b1;

  function automatic int mx(input int t);
    return t < 1 ? 1 : t;
  endfunction

  task automatic push_seg(input logic [2:0] ph, input int len, input int el);
    seg_t e;
    e.ph = ph;
    e.len = len;
    e.el = el;
    exp_q.push_back(e);
  endtask

  task automatic push_run(input int f, input int w, input int rn, input int s, input int r);
    push_seg(3'd1, mx(f), mx(f) - 1);
    for (int i = 0; i <= r; i++) begin
      push_seg(3'd2, mx(w), mx(w) - 1);
      push_seg(3'd3, mx(rn), mx(rn) - 1);
    end
`ifdef WASH_DRAIN_EN
    push_seg(3'd5, DD, DD - 1);
`endif
    push_seg(3'd4, mx(s), mx(s) - 1);
    push_seg(3'd0, 0, 0);
  endtask

  task automatic start(input int f, input int w, input int rn, input int s, input int r, input bit hold);
    fill_time = CNT_W'(f);
    wash_time = CNT_W'(w);
    rinse_time = CNT_W'(rn);
    spin_time = CNT_W'(s);
`ifdef WASH_DRAIN_EN
    drain_time = CNT_W'(DD);
`endif
    repeat_cnt = REP_W'(r);
    coin = 1'b1;
    @(negedge clk);
    coin = hold;
  endtask

  task automatic drain(input int budget_in, output int total);
    logic [2:0] cur;
    logic [CNT_W-1:0] last_el;
    int len;
    int budget;
    seg_t e;
    cur = phase;
    last_el = elapsed;
    len = 0;
    total = 0;
    budget = budget_in;
    while (exp_q.size() > 0) begin
      if (budget == 0) begin
        n_total++;
        $display("FAIL timeout: %0d segments still pending, required 0", exp_q.size());
        exp_q.delete();
        break;
      end
      if (phase !== cur) begin
        e = exp_q.pop_front();
        n_total++;
        if (cur === e.ph && len === e.len) n_pass++;
        else $display("FAIL seg_len: phase %0d lasted %0d, required phase %0d for %0d", cur, len, e.ph, e.len);
        n_total++;
        if (int'(last_el) === e.el) n_pass++;
        else $display("FAIL seg_last_elapsed: got %0d, required %0d", last_el, e.el);
        n_total++;
        if (elapsed === '0) n_pass++;
        else $display("FAIL entry_elapsed: got %0d, required 0", elapsed);
        total += len;
        cur = phase;
        len = 0;
        if (exp_q.size() > 0 && exp_q[0].ph == 3'd0) begin
          void'(exp_q.pop_front());
          n_total++;
          if (phase === 3'd0 && wash_done === 1'b1) n_pass++;
          else $display("FAIL done_pulse: phase %0d wash_done %b, required 0 and 1", phase, wash_done);
          break;
        end
      end
      last_el = elapsed;
      len++;
      budget--;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (phase === 3'd0 && busy === 1'b0 && elapsed === '0 && wash_done === 1'b0) n_pass++;
    else $display("FAIL reset_state: phase %0d busy %b elapsed %0d done %b, required 0 0 0 0", phase, busy, elapsed, wash_done);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int total;
    push_run(3, 4, 5, 6, 0);
    start(3, 4, 5, 6, 0, 1'b0);
    fill_time = 8'd9;
    wash_time = 8'd1;
    rinse_time = 8'd20;
    spin_time = 8'd2;
    repeat_cnt = 2'd3;
    drain(200, total);
    n_total++;
`ifdef WASH_DRAIN_EN
    if (total === 18 + DD) n_pass++;
    else $display("FAIL basic_total: got %0d, required %0d", total, 18 + DD);
`else
    if (total === 18) n_pass++;
    else $display("FAIL basic_total: got %0d, required 18", total);
`endif
    @(negedge clk);
    n_total++;
    if (wash_done === 1'b0 && busy === 1'b0) n_pass++;
    else $display("FAIL done_one_cycle: done %b busy %b, required 0 0", wash_done, busy);
  endtask

  task automatic test_repeat();
    int total;
    push_run(1, 2, 2, 1, 2);
    start(1, 2, 2, 1, 2, 1'b0);
    drain(200, total);
    n_total++;
`ifdef WASH_DRAIN_EN
    if (total === 14 + DD) n_pass++;
    else $display("FAIL repeat_total: got %0d, required %0d", total, 14 + DD);
`else
    if (total === 14) n_pass++;
    else $display("FAIL repeat_total: got %0d, required 14", total);
`endif
    @(negedge clk);
  endtask

  task automatic test_pause();
    int total;
    logic [CNT_W-1:0] e0;
    push_seg(3'd1, 1, 0);
    push_seg(3'd2, 11, 3);
    push_seg(3'd3, 1, 0);
`ifdef WASH_DRAIN_EN
    push_seg(3'd5, DD, DD - 1);
`endif
    push_seg(3'd4, 1, 0);
    push_seg(3'd0, 0, 0);
    start(1, 4, 1, 1, 0, 1'b0);
    fork
      drain(200, total);
      begin
        for (int i = 0; i < 50 && !(phase === 3'd2 && elapsed === 8'd1); i++) @(negedge clk);
        pause = 1'b1;
        e0 = elapsed;
        repeat (7) @(negedge clk);
        n_total++;
        if (elapsed === e0 && e0 === 8'd1 && phase === 3'd2) n_pass++;
        else $display("FAIL pause_hold: phase %0d elapsed %0d, required 2 and 1", phase, elapsed);
        pause = 1'b0;
      end
    join
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int total;
    bit saw_done;
    start(3, 4, 5, 6, 0, 1'b0);
    for (int i = 0; i < 100 && phase !== 3'd3; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    n_total++;
    if (phase === 3'd3) n_pass++;
    else $display("FAIL reach_rinse: phase %0d, required 3", phase);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_total++;
    if (phase === 3'd0 && elapsed === '0 && busy === 1'b0) n_pass++;
    else $display("FAIL mid_reset: phase %0d elapsed %0d busy %b, required 0 0 0", phase, elapsed, busy);
    saw_done = 1'b0;
    repeat (30) begin
      if (wash_done === 1'b1 || phase !== 3'd0) saw_done = 1'b1;
      @(negedge clk);
    end
    n_total++;
    if (!saw_done) n_pass++;
    else $display("FAIL aborted_run: activity or wash_done after reset, required none");
    push_run(2, 2, 2, 2, 0);
    start(2, 2, 2, 2, 0, 1'b0);
    n_total++;
    if (phase === 3'd1) n_pass++;
    else $display("FAIL restart: phase %0d, required 1", phase);
    drain(200, total);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int total;
    push_run(0, 0, 0, 0, 0);
    start(0, 0, 0, 0, 0, 1'b1);
    drain(100, total);
    n_total++;
`ifdef WASH_DRAIN_EN
    if (total === 4 + DD) n_pass++;
    else $display("FAIL zero_total: got %0d, required %0d", total, 4 + DD);
`else
    if (total === 4) n_pass++;
    else $display("FAIL zero_total: got %0d, required 4", total);
`endif
    @(negedge clk);
    coin = 1'b0;
    n_total++;
    if (phase === 3'd1 && wash_done === 1'b0) n_pass++;
    else $display("FAIL back_to_back: phase %0d done %b, required 1 0", phase, wash_done);
    push_run(0, 0, 0, 0, 0);
    drain(100, total);
    @(negedge clk);
  endtask

  task automatic test_all_ones();
    int total;
    push_run(255, 0, 0, 0, 0);
    start(255, 0, 0, 0, 0, 1'b0);
    drain(600, total);
    n_total++;
`ifdef WASH_DRAIN_EN
    if (total === 258 + DD) n_pass++;
    else $display("FAIL all_ones_total: got %0d, required %0d", total, 258 + DD);
`else
    if (total === 258) n_pass++;
    else $display("FAIL all_ones_total: got %0d, required 258", total);
`endif
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_repeat();
    test_pause();
    test_reset_mid();
    test_back_to_back();
    test_all_ones();
`ifndef WASH_DRAIN_EN
    n_total++;
    if (seen5 === 1'b0) n_pass++;
    else $display("FAIL no_drain_code: phase 5 observed, required never");
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/wash_sequencer.md
WASH_SEQUENCER -- requirements
Module: wash_sequencer

Interface
REQ-001 The block SHALL have parameter CNT_W, default 29, setting the width of the phase timer and duration inputs.
REQ-002 The block SHALL have parameter REP_W, default 2, setting the width of the repeat-count input.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-004 The block SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-005 The block SHALL have port coin, input, 1, the start request, sampled only in IDLE.
REQ-006 The block SHALL have port pause, input, 1, which freezes the active phase timer while high.
REQ-007 The block SHALL have port repeat_cnt, input, REP_W, the number of extra wash+rinse passes (0 = single pass).
REQ-008 The block SHALL have ports fill_time, wash_time, rinse_time and spin_time, each input, CNT_W, giving phase durations in clk cycles.
REQ-009 The block SHALL have port phase, output, 3, the current state encoding.
REQ-010 The block SHALL have port busy, output, 1, high whenever phase is not IDLE.
REQ-011 The block SHALL have port elapsed, output, CNT_W, the current phase timer value.
REQ-012 The block SHALL have port wash_done, output, 1, a one-cycle completion pulse.

Function
REQ-013 The state machine SHALL use these encodings: IDLE=0, FILLING=1, WASHING=2, RINSING=3, SPINNING=4, DRAIN=5 (DRAIN only with the macro); codes 6 and 7 SHALL return to IDLE on the next edge.
REQ-014 When phase=IDLE and coin=1 at a rising edge, the block SHALL latch all duration inputs and repeat_cnt, and phase SHALL equal FILLING on the next cycle.
REQ-015 Duration and repeat inputs SHALL be ignored outside IDLE; changes mid-cycle SHALL have no effect until the next start.
REQ-016 elapsed SHALL be 0 on phase entry and SHALL increment by 1 per unpaused cycle.
REQ-017 A phase with latched duration T SHALL end on the edge where elapsed==T-1 and pause=0; a duration of 0 SHALL be treated as 1.
REQ-018 An unpaused phase SHALL therefore last exactly max(T,1) cycles.
REQ-019 While pause=1 in any active phase, elapsed and phase SHALL hold; pause SHALL have no effect in IDLE.
REQ-020 The phase sequence SHALL be: FILLING to WASHING, then WASHING to RINSING.
REQ-021 At the end of RINSING with passes remaining > 0, the block SHALL go to WASHING and decrement the remaining-pass count.
REQ-022 At the end of RINSING with no passes remaining, the block SHALL go to SPINNING (or to DRAIN with the macro).
REQ-023 At the end of SPINNING the block SHALL go to IDLE, and wash_done SHALL be 1 for exactly the first IDLE cycle.
REQ-024 If coin=1 during the wash_done cycle, the block SHALL accept it, and phase SHALL equal FILLING on the next cycle.
REQ-025 With no pause, the number of cycles from coin acceptance to wash_done SHALL be F+(R+1)(W+Rn)+S (+D with the macro), where each term is max(T,1).
REQ-026 elapsed SHALL NOT wrap: it is bounded by T-1 at most 2^CNT_W-2.
REQ-027 A duration of all-ones SHALL be legal and SHALL last 2^CNT_W-1 cycles.

Reset
REQ-028 While reset=1 at a rising edge, the block SHALL set phase=IDLE, elapsed=0, busy=0, wash_done=0 and clear the latched configuration, regardless of state.
REQ-029 A reset asserted mid-cycle SHALL abort the run with no wash_done pulse.
REQ-030 Reset SHALL take priority over coin and pause.

Configuration
REQ-031 With macro WASH_DRAIN_EN defined, the block SHALL add port drain_time (input, CNT_W, latched at start) and state DRAIN=5, inserted between the final RINSING and SPINNING, obeying REQ-016 to REQ-019.
REQ-032 Without WASH_DRAIN_EN, the drain_time port SHALL be absent, RINSING SHALL go directly to SPINNING, and phase SHALL never equal 5.

Verification
REQ-033 Basic run: coin pulse, fill/wash/rinse/spin=3/4/5/6, repeat_cnt=0 -> phases 1,2,3,4 lasting 3,4,5,6 cycles; wash_done pulse 18 cycles after the coin edge.
REQ-034 Repeat: repeat_cnt=2, wash=2, rinse=2, fill=spin=1 -> sequence W,R,W,R,W,R then SPINNING; total 14 cycles.
REQ-035 Pause: pause high 7 cycles mid-WASHING (wash=4) -> elapsed frozen; WASHING lasts 11 cycles; no transition while paused.
REQ-036 Reset mid-RINSING -> phase=0, elapsed=0 next cycle; no wash_done; later coin restarts at FILLING.
REQ-037 Zero duration with back-to-back start: all durations 0 -> each phase lasts 1 cycle; coin held high gives wash_done and FILLING on consecutive cycles.
REQ-038 WASH_DRAIN_EN: drain=3 -> DRAIN (5) lasts 3 cycles between RINSING and SPINNING; without the macro, code 5 is never observed.
